// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient}. Define DIV_ZERO_FAST_EN to short-cut a zero divisor.
module div_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_signed_div,
    input  logic [31:0] i_opa,
    input  logic [31:0] i_opb,
    input  logic        i_annul,
    output logic        o_busy,
    output logic        o_ready,
    output logic [63:0] o_result
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_result;

    logic        w_accept;
    logic        w_zero_div;
    logic [32:0] w_rem_sh;
    logic        w_keep;
    logic [31:0] w_diff;
    logic [31:0] w_rem_step;
    logic [31:0] w_quo_step;
    logic [63:0] w_fixed;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

    assign w_accept = i_start && !i_annul;

`ifdef DIV_ZERO_FAST_EN
    assign w_zero_div = (i_opb == 32'd0);
`else
    assign w_zero_div = 1'b0;
`endif

    // Next-state decode; annul overrides every non-idle transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_zero_div ? S_DIVZERO : S_ON;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ON: begin
                if (i_annul) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == 5'd31) begin
                    w_state_next = S_END;
                end else begin
                    w_state_next = S_ON;
                end
            end
            S_DIVZERO: begin
                if (i_annul) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_END;
                end
            end
            S_END:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // One restoring step plus the sign fix applied to its outcome.
    always_comb begin
        w_rem_sh   = {r_rem, r_quo[31]};
        w_keep     = (w_rem_sh >= {1'b0, r_div});
        // When the trial succeeds the true difference fits in 32 bits.
        w_diff     = w_rem_sh[31:0] - r_div;
        w_rem_step = w_rem_sh[31:0];
        w_quo_step = {r_quo[30:0], 1'b0};
        if (w_keep) begin
            w_rem_step = w_diff;
            w_quo_step = {r_quo[30:0], 1'b1};
        end else begin
            w_rem_step = w_rem_sh[31:0];
            w_quo_step = {r_quo[30:0], 1'b0};
        end
        w_fixed = {(r_neg_r ? neg32(w_rem_step) : w_rem_step),
                   (r_neg_q ? neg32(w_quo_step) : w_quo_step)};
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= 5'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_div    <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= 5'd0;
                        r_rem   <= 32'd0;
                        r_quo   <= mag32(i_opa, i_signed_div);
                        r_div   <= mag32(i_opb, i_signed_div);
                        r_neg_q <= i_signed_div & (i_opa[31] ^ i_opb[31]);
                        r_neg_r <= i_signed_div & i_opa[31];
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                S_ON: begin
                    r_rem <= w_rem_step;
                    r_quo <= w_quo_step;
                    r_cnt <= r_cnt + 5'd1;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
            // The result only moves on a genuine entry to END, so an annul keeps it.
            if (w_state_next == S_END) begin
                r_result <= (r_state == S_DIVZERO) ? 64'd0 : w_fixed;
            end else begin
                r_result <= r_result;
            end
        end
    end

    assign o_busy   = (r_state != S_IDLE);
    assign o_ready  = (r_state == S_END) && !i_annul;
    assign o_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit with hand-computed results and
// cycle-exact latency checks; honours DIV_ZERO_FAST_EN for the zero-divisor vector.
module tb_div_unit;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic        i_signed_div;
    logic [31:0] i_opa;
    logic [31:0] i_opb;
    logic        i_annul;
    logic        o_busy;
    logic        o_ready;
    logic [63:0] o_result;

    int total;
    int bad;
    logic [63:0] last_exp;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[10];

    div_unit dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_signed_div (i_signed_div),
        .i_opa        (i_opa),
        .i_opb        (i_opb),
        .i_annul      (i_annul),
        .o_busy       (o_busy),
        .o_ready      (o_ready),
        .o_result     (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge i_clk);
        #1;
        i_opa        = a;
        i_opb        = b;
        i_signed_div = s;
        i_start      = 1'b1;
    endtask

    // Current time is just after the edge opening cycle T+n0; counts cycles until ready.
    task automatic wait_done(input logic [63:0] exp, input int lat, input int n0, input string name);
        int n;
        bit got;
        bit busy_ok;
        n       = n0;
        got     = 1'b0;
        busy_ok = 1'b1;
        while (!got && n < 60) begin
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
            n++;
            @(negedge i_clk);
            if (o_ready) begin
                got = 1'b1;
            end else if (!o_busy) begin
                busy_ok = 1'b0;
            end
        end
        check({name, "_ready_seen"}, {63'd0, got}, 64'd1);
        check({name, "_latency"}, 64'(n), 64'(lat));
        check({name, "_result"}, o_result, exp);
        check({name, "_busy_end"}, {63'd0, o_busy}, 64'd1);
        check({name, "_busy_during"}, {63'd0, busy_ok}, 64'd1);
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        check({name, "_busy_after"}, {63'd0, o_busy}, 64'd0);
        check({name, "_ready_after"}, {63'd0, o_ready}, 64'd0);
        check({name, "_result_hold"}, o_result, exp);
        last_exp = exp;
    endtask

    initial begin
        bit saw;
        total        = 0;
        bad          = 0;
        last_exp     = 64'd0;
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_signed_div = 1'b0;
        i_opa        = 32'd0;
        i_opb        = 32'd0;
        i_annul      = 1'b0;

        vecs[0] = '{32'd100,       32'd7,          1'b0, {32'd2,          32'd14},         33, "u_100_7"};
        vecs[1] = '{32'hFFFFFFF9,  32'd2,          1'b1, {32'hFFFFFFFF,   32'hFFFFFFFD},   33, "s_m7_2"};
        vecs[2] = '{32'd7,         32'hFFFFFFFE,   1'b1, {32'h00000001,   32'hFFFFFFFD},   33, "s_7_m2"};
        vecs[3] = '{32'h80000000,  32'hFFFFFFFF,   1'b1, {32'h00000000,   32'h80000000},   33, "s_min_m1"};
        vecs[4] = '{32'hFFFFFFFF,  32'd1,          1'b0, {32'h00000000,   32'hFFFFFFFF},   33, "u_max_1"};
`ifdef DIV_ZERO_FAST_EN
        vecs[5] = '{32'd5,         32'd0,          1'b0, 64'd0,                            2,  "u_5_0_fast"};
`else
        vecs[5] = '{32'd5,         32'd0,          1'b0, {32'd5,          32'hFFFFFFFF},   33, "u_5_0"};
`endif
        vecs[6] = '{32'd1000,      32'd1000,       1'b1, {32'd0,          32'd1},          33, "s_eq"};
        vecs[7] = '{32'hFFFFFF9C,  32'hFFFFFFF9,   1'b1, {32'hFFFFFFFE,   32'h0000000E},   33, "s_m100_m7"};
        vecs[8] = '{32'hFFFFFFFF,  32'h00000010,   1'b0, {32'h0000000F,   32'h0FFFFFFF},   33, "u_max_16"};
        vecs[9] = '{32'd3,         32'd7,          1'b0, {32'd3,          32'd0},          33, "u_3_7"};

        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("reset_busy",   {63'd0, o_busy},  64'd0);
        check("reset_ready",  {63'd0, o_ready}, 64'd0);
        check("reset_result", o_result,         64'd0);

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_done(vecs[i].exp, vecs[i].lat, 0, vecs[i].name);
        end

        // Flush at T+10, restart with 9/3 at T+11.
        launch(32'd100, 32'd7, 1'b0);
        saw = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
            if (c == 10) i_annul = 1'b1;
            @(negedge i_clk);
            if (o_ready) saw = 1'b1;
        end
        @(posedge i_clk);
        #1;
        i_annul = 1'b0;
        i_opa   = 32'd9;
        i_opb   = 32'd3;
        i_signed_div = 1'b0;
        i_start = 1'b1;
        @(negedge i_clk);
        check("annul_no_ready", {63'd0, saw},     64'd0);
        check("annul_busy",     {63'd0, o_busy},  64'd0);
        check("annul_ready",    {63'd0, o_ready}, 64'd0);
        check("annul_result",   o_result,         last_exp);
        wait_done({32'd0, 32'd3}, 33, 0, "restart_9_3");

        // Flush during the END cycle suppresses ready.
        launch(32'd100, 32'd7, 1'b0);
        saw = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
            if (c == 33) i_annul = 1'b1;
            @(negedge i_clk);
            if (o_ready) saw = 1'b1;
            if (c == 33) check("end_annul_busy", {63'd0, o_busy}, 64'd1);
        end
        check("end_annul_no_ready", {63'd0, saw}, 64'd0);
        @(posedge i_clk);
        #1;
        i_annul = 1'b0;
        @(negedge i_clk);
        check("end_annul_idle", {63'd0, o_busy}, 64'd0);

        // Start pulse during ON must be ignored.
        launch(32'd100, 32'd7, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge i_clk);
            #1;
            i_start = (c == 5);
            if (c == 5) begin
                i_opa = 32'd9;
                i_opb = 32'd3;
            end
        end
        wait_done({32'd2, 32'd14}, 33, 5, "ignore_start");

        // Reset at T+5 discards the operation.
        launch(32'd100, 32'd7, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
            if (c == 5) i_rst = 1'b1;
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("midrst_busy",   {63'd0, o_busy},  64'd0);
        check("midrst_ready",  {63'd0, o_ready}, 64'd0);
        check("midrst_result", o_result,         64'd0);
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge i_clk);
            if (o_ready || o_busy) saw = 1'b1;
        end
        check("midrst_quiet", {63'd0, saw}, 64'd0);

        launch(32'd9, 32'd3, 1'b0);
        wait_done({32'd0, 32'd3}, 33, 0, "post_rst_9_3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider serving DIV/DIVU in the execute stage, downstream of the main decoder's `hilowrite = 2'b11` decode for those instructions. It accepts a dividend and divisor and computes quotient and remainder one bit per cycle with a restoring algorithm. It raises `busy` so the pipeline controller can stall, then pulses `ready` with the 64-bit `{remainder, quotient}` result for the HI/LO write.

## Interface
- Parameters: none; the datapath is fixed at 32 bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU; sampled with `start`.
- `opa`  in  32  dividend; sampled with `start`.
- `opb`  in  32  divisor; sampled with `start`.
- `annul`  in  1  pipeline flush; aborts any in-flight division.
- `busy`  out  1  high whenever state is not IDLE.
- `ready`  out  1  one-cycle pulse, high while `result` becomes valid.
- `result`  out  64  `{hi = remainder, lo = quotient}`.

## Operation
- States: IDLE, DIVZERO, ON, END.
- **IDLE**
  - `start=1` and `annul=0` latches the operands and `signed_div`.
  - Signed mode converts both operands to magnitudes; the dividend sign and the quotient sign (`opa[31]^opb[31]`) are recorded.
  - Next state is DIVZERO if `opb==0` and `DIV_ZERO_FAST_EN` is defined, otherwise ON. The iteration counter is cleared to 0.
- **ON:** one restoring step per cycle.
  - Shift `{rem, quo}` left by 1.
  - Trial subtract: `rem − |divisor|`, 33-bit wide.
  - If the trial result is non-negative, keep it as `rem` and set the quotient LSB to 1; otherwise restore and set it to 0.
  - The counter increments each step; after step 31 the next state is END.
- **DIVZERO:** the result is forced to 0 and the next state is END.
- **Sign fix, on entry to END:**
  - Signed mode only: negate the quotient if the quotient sign is 1, and negate the remainder if the dividend was negative.
  - Two's-complement wrap applies, so `0x80000000 / −1` gives quotient `0x80000000`, remainder 0.
- **END:**
  - `ready=1` for exactly this cycle and `result` is valid.
  - Next state is unconditionally IDLE.
  - `result` holds its value until the next accepted `start`.
- `start` while `busy=1` is ignored; the operands are not re-latched.
- **annul:**
  - `annul=1` in any state other than IDLE sends the next state to IDLE.
  - `ready` does not pulse and `result` is left unchanged.
  - `annul` in END suppresses that cycle's `ready`.
  - `annul` together with `start` in IDLE takes no action.
- **Reset:** state IDLE, `busy=0`, `ready=0`, `result=0`, counter 0. Reset in the middle of an operation discards it; there is no `ready`.

## Timing
- Cycle T: `start=1` in IDLE.
- T+1 … T+32: state ON, 32 iterations.
- T+33: END, `ready=1`, `result` valid. Latency is 33 cycles.
- Zero-divisor path with the macro: T+1 DIVZERO, T+2 END with `ready=1`.
- `busy` is high from T+1 through the END cycle inclusive, and low at END+1.
- A new `start` is accepted in the cycle after END. There is no back-to-back overlap.
- `annul` at cycle X, with state not IDLE: `busy=0` at X+1, and `start` at X+1 is accepted.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - A zero divisor goes through DIVZERO.
  - Result is `{32'h0, 32'h0}` at T+2.
- `DIV_ZERO_FAST_EN` undefined:
  - A zero divisor runs the normal 33-cycle path.
  - Unsigned mode yields quotient `0xFFFFFFFF`, remainder = `opa`.
  - Signed mode yields the same raw values with the normal sign fix applied. MIPS leaves this result architecturally UNPREDICTABLE; the bench checks unsigned only.

## Test plan
- Unsigned, `opa=100`, `opb=7` -> `ready` at T+33, `result = {32'd2, 32'd14}`, `busy` high for T+1..T+33.
- Signed, `opa=−7` (`0xFFFFFFF9`), `opb=2` -> `result = {0xFFFFFFFF, 0xFFFFFFFD}`; also `opa=7`, `opb=−2` -> `{0x00000001, 0xFFFFFFFD}`.
- Signed, `0x80000000 / 0xFFFFFFFF` -> `{0x00000000, 0x80000000}`; unsigned `0xFFFFFFFF / 1` -> `{0, 0xFFFFFFFF}`.
- Divide by zero, unsigned, `opa=5`:
  - With `DIV_ZERO_FAST_EN` -> `ready` at T+2, `result = 0`.
  - Without it -> `ready` at T+33, `result = {5, 0xFFFFFFFF}`.
- Flush and restart:
  - Assert `annul` at T+10 -> `busy=0` at T+11, no `ready`, `result` unchanged.
  - Then `start` with 9/3 at T+11 -> `ready` at T+44 with `{0, 3}`.
- Protocol robustness:
  - `start` pulses during ON are ignored; the original 100/7 result is returned.
  - `rst` at T+5 -> all outputs 0 next cycle, no `ready`.
